// File: rtl/mac_pipe_if.sv
// Operand/result handshake bundle for mac_pipe; the slave modport is the MAC side.
interface mac_pipe_if #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 80
);
    logic                   i_valid;
    logic                   o_ready;
    logic                   i_multa_ns;
    logic                   i_multb_ns;
    logic [WIDTH-1:0]       i_multa;
    logic [WIDTH-1:0]       i_multb;
    logic                   i_acc_en;
    logic                   i_acc_clr;
    logic                   o_valid;
    logic                   i_ready;
    logic [2*WIDTH-1:0]     o_product;
    logic [ACC_WIDTH-1:0]   o_acc;
    logic                   o_ovf;

    modport slave (
        input  i_valid, i_multa_ns, i_multb_ns, i_multa, i_multb,
               i_acc_en, i_acc_clr, i_ready,
        output o_ready, o_valid, o_product, o_acc, o_ovf
    );

    modport master (
        output i_valid, i_multa_ns, i_multb_ns, i_multa, i_multb,
               i_acc_en, i_acc_clr, i_ready,
        input  o_ready, o_valid, o_product, o_acc, o_ovf
    );
endinterface

// File: rtl/mac_pipe.sv
// Pipelined signed/unsigned multiply-accumulate with global stall and sticky overflow.
// Define MAC_SAT_EN to saturate the accumulator on signed overflow instead of wrapping.
module mac_pipe #(
    parameter int WIDTH     = 32,
    parameter int ACC_WIDTH = 80,
    parameter int PIPE      = 3
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    mac_pipe_if.slave   bus
);
    // Stage 0 holds extended operands; stages 1..PIPE-1 hold the product, last one is the output.
    localparam int unsigned NS = PIPE - 1;

    typedef logic signed [2*WIDTH-1:0] prod_t;
    typedef logic [ACC_WIDTH-1:0]      acc_t;

    localparam acc_t SAT_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
    localparam acc_t SAT_MIN = ~SAT_MAX;

    typedef struct packed {
        logic               vld;
        logic [1:0]         ns;
        logic               en;
        logic               clr;
        logic [2*WIDTH-1:0] prod;
    } stage_t;

    logic                 s0_vld_q, s0_vld_d;
    logic signed [WIDTH:0] s0_a_q, s0_a_d;
    logic signed [WIDTH:0] s0_b_q, s0_b_d;
    logic [1:0]           s0_ns_q, s0_ns_d;
    logic                 s0_en_q, s0_en_d;
    logic                 s0_clr_q, s0_clr_d;
    stage_t               st_q [NS];
    stage_t               st_d [NS];
    acc_t                 acc_q, acc_d;
    logic                 ovf_q, ovf_d;

    logic   ready;
    prod_t  a_x, b_x, mul_res;
    stage_t inc;
    acc_t   base, ext, sum;
    logic   ovf_now;

    always_comb begin
        ready    = ~(st_q[NS-1].vld & ~bus.i_ready);
        s0_vld_d = s0_vld_q;
        s0_a_d   = s0_a_q;
        s0_b_d   = s0_b_q;
        s0_ns_d  = s0_ns_q;
        s0_en_d  = s0_en_q;
        s0_clr_d = s0_clr_q;
        st_d     = st_q;
        acc_d    = acc_q;
        ovf_d    = ovf_q;
        inc      = st_q[NS-1];
        base     = '0;
        ext      = '0;
        sum      = '0;
        ovf_now  = 1'b0;

        a_x     = prod_t'(s0_a_q);
        b_x     = prod_t'(s0_b_q);
        mul_res = a_x * b_x;

        if (ready) begin
            s0_vld_d = bus.i_valid;
            if (bus.i_valid) begin
                s0_a_d   = bus.i_multa_ns ? {1'b0, bus.i_multa} : {bus.i_multa[WIDTH-1], bus.i_multa};
                s0_b_d   = bus.i_multb_ns ? {1'b0, bus.i_multb} : {bus.i_multb[WIDTH-1], bus.i_multb};
                s0_ns_d  = {bus.i_multa_ns, bus.i_multb_ns};
                s0_en_d  = bus.i_acc_en;
                s0_clr_d = bus.i_acc_clr;
            end

            st_d[0].vld  = s0_vld_q;
            st_d[0].ns   = s0_ns_q;
            st_d[0].en   = s0_en_q;
            st_d[0].clr  = s0_clr_q;
            st_d[0].prod = mul_res;
            for (int unsigned i = 1; i < NS; i++) begin
                st_d[i] = st_q[i-1];
            end

            // Accumulate as the operation lands in the output stage.
            inc = st_d[NS-1];
            if (inc.vld) begin
                base  = inc.clr ? '0 : acc_q;
                ovf_d = inc.clr ? 1'b0 : ovf_q;
                if (inc.en) begin
                    ext     = (&inc.ns) ? acc_t'(inc.prod) : acc_t'(prod_t'(inc.prod));
                    sum     = base + ext;
                    ovf_now = (base[ACC_WIDTH-1] == ext[ACC_WIDTH-1]) &&
                              (sum[ACC_WIDTH-1] != base[ACC_WIDTH-1]);
`ifdef MAC_SAT_EN
                    acc_d = ovf_now ? (base[ACC_WIDTH-1] ? SAT_MIN : SAT_MAX) : sum;
`else
                    acc_d = sum;
`endif
                    ovf_d = ovf_d | ovf_now;
                end else begin
                    acc_d = base;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            s0_vld_q <= 1'b0;
            s0_a_q   <= '0;
            s0_b_q   <= '0;
            s0_ns_q  <= '0;
            s0_en_q  <= 1'b0;
            s0_clr_q <= 1'b0;
            for (int unsigned i = 0; i < NS; i++) begin
                st_q[i] <= '0;
            end
            acc_q    <= '0;
            ovf_q    <= 1'b0;
        end else begin
            s0_vld_q <= s0_vld_d;
            s0_a_q   <= s0_a_d;
            s0_b_q   <= s0_b_d;
            s0_ns_q  <= s0_ns_d;
            s0_en_q  <= s0_en_d;
            s0_clr_q <= s0_clr_d;
            st_q     <= st_d;
            acc_q    <= acc_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.o_ready   = ready;
    assign bus.o_valid   = st_q[NS-1].vld;
    assign bus.o_product = st_q[NS-1].prod;
    assign bus.o_acc     = acc_q;
    assign bus.o_ovf     = ovf_q;
endmodule

// File: tb/tb_mac_pipe.sv
// Directed self-checking bench: a 32x32/80-bit PIPE=3 MAC plus an 8x8/16-bit PIPE=2 MAC for overflow.
module tb_mac_pipe;
    logic clk = 1'b0;
    logic rstn;
    always #5 clk = ~clk;

    mac_pipe_if #(.WIDTH(32), .ACC_WIDTH(80)) bus ();
    mac_pipe_if #(.WIDTH(8),  .ACC_WIDTH(16)) sbus ();

    mac_pipe #(.WIDTH(32), .ACC_WIDTH(80), .PIPE(3)) u_dut (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (bus)
    );

    mac_pipe #(.WIDTH(8), .ACC_WIDTH(16), .PIPE(2)) u_small (
        .i_clk  (clk),
        .i_rstn (rstn),
        .bus    (sbus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic put(input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ans, input logic bns, input logic en, input logic clr);
        bus.i_valid    = v;
        bus.i_multa    = a;
        bus.i_multb    = b;
        bus.i_multa_ns = ans;
        bus.i_multb_ns = bns;
        bus.i_acc_en   = en;
        bus.i_acc_clr  = clr;
    endtask

    task automatic sput(input logic v, input logic [7:0] a, input logic [7:0] b,
                        input logic ans, input logic bns, input logic en, input logic clr);
        sbus.i_valid    = v;
        sbus.i_multa    = a;
        sbus.i_multb    = b;
        sbus.i_multa_ns = ans;
        sbus.i_multb_ns = bns;
        sbus.i_acc_en   = en;
        sbus.i_acc_clr  = clr;
    endtask

    initial begin
        rstn = 1'b0;
        put(0, 0, 0, 0, 0, 0, 0);
        sput(0, 0, 0, 0, 0, 0, 0);
        bus.i_ready  = 1'b1;
        sbus.i_ready = 1'b1;
        tick();
        tick();
        chk("rst_valid", bus.o_valid, 0);
        chk("rst_product", bus.o_product, 0);
        chk("rst_acc", bus.o_acc, 0);
        chk("rst_ovf", bus.o_ovf, 0);
        chk("rst_small_valid", sbus.o_valid, 0);
        rstn = 1'b1;
        tick();
        chk("ready_after_rst", bus.o_ready, 1);

        // Product signedness and PIPE=3 latency
        put(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 0, 0);
        tick();
        put(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        tick();
        chk("lat_not_early", bus.o_valid, 0);
        put(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 0);
        tick();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("lat_valid", bus.o_valid, 1);
        chk("prod_uu", bus.o_product, 64'hFFFF_FFFE_0000_0001);
        chk("acc_untouched", bus.o_acc, 0);
        tick();
        chk("prod_ss", bus.o_product, 64'h1);
        tick();
        chk("prod_us", bus.o_product, 64'hFFFF_FFFF_0000_0001);
        tick();
        chk("idle_valid", bus.o_valid, 0);

        // Back-to-back accumulate 3*5, clear on first
        put(1, 3, 5, 0, 0, 1, 1);
        tick();
        put(1, 3, 5, 0, 0, 1, 0);
        tick();
        tick();
        chk("acc_15", bus.o_acc, 15);
        chk("acc_15_valid", bus.o_valid, 1);
        tick();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("acc_30", bus.o_acc, 30);
        tick();
        chk("acc_45", bus.o_acc, 45);
        tick();
        chk("acc_60", bus.o_acc, 60);
        chk("acc_60_valid", bus.o_valid, 1);
        chk("acc_no_ovf", bus.o_ovf, 0);
        tick();
        chk("acc_done_valid", bus.o_valid, 0);

        // Stall with a full pipeline
        bus.i_ready = 1'b0;
        put(1, 1, 1, 0, 0, 0, 0);
        tick();
        put(1, 2, 1, 0, 0, 0, 0);
        tick();
        put(1, 3, 1, 0, 0, 0, 0);
        tick();
        put(1, 4, 1, 0, 0, 0, 0);
        chk("stall_valid", bus.o_valid, 1);
        chk("stall_ready", bus.o_ready, 0);
        chk("stall_prod", bus.o_product, 1);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("stall_hold_valid", bus.o_valid, 1);
            chk("stall_hold_ready", bus.o_ready, 0);
            chk("stall_hold_prod", bus.o_product, 1);
        end
        chk("stall_acc_hold", bus.o_acc, 60);
        bus.i_ready = 1'b1;
        #1;
        chk("release_ready", bus.o_ready, 1);
        tick();
        put(0, 0, 0, 0, 0, 0, 0);
        chk("order_2", bus.o_product, 2);
        tick();
        chk("order_3", bus.o_product, 3);
        tick();
        chk("order_4", bus.o_product, 4);
        chk("order_4_valid", bus.o_valid, 1);
        tick();
        chk("order_end_valid", bus.o_valid, 0);

        // Reset with two operations in flight
        put(1, 3, 5, 0, 0, 1, 0);
        tick();
        tick();
        put(0, 0, 0, 0, 0, 0, 0);
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        chk("midrst_valid", bus.o_valid, 0);
        chk("midrst_acc", bus.o_acc, 0);
        chk("midrst_product", bus.o_product, 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("midrst_no_stale", bus.o_valid, 0);
        end

        // Small MAC (PIPE=2): build acc up to 0x7FFF, then overflow
        sput(1, 8'd127, 8'd127, 0, 0, 1, 1);
        tick();
        sput(1, 8'd127, 8'd127, 0, 0, 1, 0);
        tick();
        chk("s_lat2_valid", sbus.o_valid, 1);
        chk("s_acc_3f01", sbus.o_acc, 16'h3F01);
        sput(1, 8'd127, 8'd4, 0, 0, 1, 0);
        tick();
        chk("s_acc_7e02", sbus.o_acc, 16'h7E02);
        sput(1, 8'd1, 8'd1, 0, 0, 1, 0);
        tick();
        chk("s_prod_1fc", sbus.o_product, 16'h01FC);
        chk("s_acc_7ffe", sbus.o_acc, 16'h7FFE);
        sput(1, 8'd1, 8'd1, 0, 0, 1, 0);
        tick();
        chk("s_acc_max", sbus.o_acc, 16'h7FFF);
        chk("s_no_ovf_yet", sbus.o_ovf, 0);
        sput(1, 8'd1, 8'd1, 0, 0, 1, 0);
        tick();
`ifdef MAC_SAT_EN
        chk("s_ovf_acc", sbus.o_acc, 16'h7FFF);
`else
        chk("s_ovf_acc", sbus.o_acc, 16'h8000);
`endif
        chk("s_ovf_set", sbus.o_ovf, 1);
        sput(1, 8'd2, 8'd3, 0, 0, 1, 1);
        tick();
`ifdef MAC_SAT_EN
        chk("s_after_ovf_acc", sbus.o_acc, 16'h7FFF);
`else
        chk("s_after_ovf_acc", sbus.o_acc, 16'h8001);
`endif
        chk("s_ovf_sticky", sbus.o_ovf, 1);
        sput(1, 8'hFF, 8'd1, 0, 0, 1, 0);
        tick();
        chk("s_clr_acc", sbus.o_acc, 16'd6);
        chk("s_clr_ovf", sbus.o_ovf, 0);
        sput(1, 8'hFF, 8'hFF, 1, 1, 0, 0);
        tick();
        sput(0, 0, 0, 0, 0, 0, 0);
        chk("s_prod_neg1", sbus.o_product, 16'hFFFF);
        chk("s_acc_sub", sbus.o_acc, 16'd5);
        tick();
        chk("s_prod_uu", sbus.o_product, 16'hFE01);
        chk("s_acc_noen", sbus.o_acc, 16'd5);
        tick();
        chk("s_end_valid", sbus.o_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
